// File: rtl/ks_delay_if.sv
// Control and sample bus between the Karplus-Strong voice controller,
// the delay line, and the feedback lowpass filter.
interface ks_delay_if #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 24
);
    logic        [DEPTH_LOG2-1:0] period;
    logic                         pluck;
    logic        [WIDTH-2:0]      amplitude;
    logic signed [WIDTH-1:0]      fb_in;
    logic signed [WIDTH-1:0]      tap_out;
    logic                         busy;

    modport master (
        output period, pluck, amplitude, fb_in,
        input  tap_out, busy
    );

    modport slave (
        input  period, pluck, amplitude, fb_in,
        output tap_out, busy
    );
endinterface

// File: rtl/ks_delay_line.sv
// Circular-buffer delay line for a Karplus-Strong string voice: clears the
// buffer, injects a period-long noise burst on pluck, then recirculates fb_in.
module ks_delay_line #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 24
) (
    input  logic      lrck,
    input  logic      rst_n,
    ks_delay_if.slave bus
);
    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [23:0] LFSR_MASK = 24'hE10000;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        RUN    = 2'd1,
        EXCITE = 2'd2
    } state_t;

    logic signed [WIDTH-1:0] mem [0:DEPTH-1];

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   ptr, ptr_d, ptr_adv;
    logic [DEPTH_LOG2-1:0]   clr_cnt, clr_cnt_d;
    logic [DEPTH_LOG2-1:0]   exc_cnt, exc_cnt_d;
    logic [DEPTH_LOG2-1:0]   p_eff, p_last;
    logic                    pluck_d, pluck_pend, pend_d, rise;
    logic                    busy_q, busy_d;
    logic                    wr_en;
    logic [DEPTH_LOG2-1:0]   wr_addr;
    logic signed [WIDTH-1:0] wr_data, noise, tap_q;
    logic [23:0]             lfsr;

    // Symmetric binary noise; amplitude is one bit narrower than the sample,
    // so negation can never overflow.
    function automatic logic signed [WIDTH-1:0] noise_sample(
        input logic             neg,
        input logic [WIDTH-2:0] amp
    );
        logic signed [WIDTH-1:0] mag;
        mag = $signed({1'b0, amp});
        return neg ? -mag : mag;
    endfunction

    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return {1'b0, s[23:1]} ^ (s[0] ? LFSR_MASK : 24'h000000);
    endfunction

    assign p_eff   = (bus.period < DEPTH_LOG2'(2)) ? DEPTH_LOG2'(2) : bus.period;
    assign p_last  = p_eff - DEPTH_LOG2'(1);
    // A pointer left beyond a shrunken period wraps straight back to 0.
    assign ptr_adv = (ptr >= p_last) ? '0 : ptr + DEPTH_LOG2'(1);
    assign rise    = bus.pluck & ~pluck_d;
    assign noise   = noise_sample(lfsr[0], bus.amplitude);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr;
        clr_cnt_d = clr_cnt;
        exc_cnt_d = exc_cnt;
        pend_d    = pluck_pend;
        wr_en     = 1'b0;
        wr_addr   = ptr;
        wr_data   = bus.fb_in;
        case (state_q)
            CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt;
                wr_data   = '0;
                clr_cnt_d = clr_cnt + DEPTH_LOG2'(1);
                ptr_d     = '0;
                pend_d    = pluck_pend | rise;
                if (clr_cnt == {DEPTH_LOG2{1'b1}}) begin
                    state_d   = (pluck_pend | rise) ? EXCITE : RUN;
                    pend_d    = 1'b0;
                    exc_cnt_d = '0;
                end
            end
            RUN: begin
                wr_en = 1'b1;
                ptr_d = ptr_adv;
                if (rise) begin
                    state_d   = EXCITE;
                    exc_cnt_d = '0;
                end
            end
            EXCITE: begin
                wr_en   = 1'b1;
                wr_data = noise;
                ptr_d   = ptr_adv;
                if (rise) begin
                    exc_cnt_d = '0;
                end else if (exc_cnt == p_last) begin
                    state_d = RUN;
                end else begin
                    exc_cnt_d = exc_cnt + DEPTH_LOG2'(1);
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
        busy_d = (state_d != RUN);
    end

    always_ff @(posedge lrck) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            ptr        <= '0;
            clr_cnt    <= '0;
            exc_cnt    <= '0;
            pluck_d    <= 1'b0;
            pluck_pend <= 1'b0;
            busy_q     <= 1'b1;
            tap_q      <= '0;
            lfsr       <= 24'h000001;
        end else begin
            state_q    <= state_d;
            ptr        <= ptr_d;
            clr_cnt    <= clr_cnt_d;
            exc_cnt    <= exc_cnt_d;
            pluck_d    <= bus.pluck;
            pluck_pend <= pend_d;
            busy_q     <= busy_d;
            tap_q      <= (state_q == CLEAR) ? '0 : mem[ptr];
            lfsr       <= lfsr_step(lfsr);
        end
    end

    // Read-before-write at ptr: tap_q above samples the old contents.
    always_ff @(posedge lrck) begin
        if (rst_n && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign bus.tap_out = tap_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_ks_delay_line.sv
// Directed bench for ks_delay_line: clear sequence, noise excitation against
// a reference LFSR, feedback delay, period clamping, re-pluck and reset abort.
module tb_ks_delay_line;
    logic lrck = 1'b0;
    logic rst_n = 1'b0;

    ks_delay_if #(.DEPTH_LOG2(10), .WIDTH(24)) bus ();

    ks_delay_line #(.DEPTH_LOG2(10), .WIDTH(24)) dut (
        .lrck  (lrck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 lrck = ~lrck;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    logic [23:0] lfsr_m = 24'h000001;
    logic signed [23:0] noise_hist [0:32767];

    function automatic logic [23:0] model_step(input logic [23:0] s);
        logic [23:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 24'hE10000;
        return n;
    endfunction

    function automatic logic signed [23:0] model_noise(input logic neg, input logic [22:0] amp);
        logic [23:0] mag;
        mag = {1'b0, amp};
        return neg ? $signed(~mag + 24'd1) : $signed(mag);
    endfunction

    // Reference noise per lrck edge, indexed by edge number.
    always @(posedge lrck) begin
        if (!rst_n) begin
            lfsr_m <= 24'h000001;
        end else begin
            noise_hist[cyc[14:0]] <= model_noise(lfsr_m[0], bus.amplitude);
            lfsr_m <= model_step(lfsr_m);
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge lrck);
        @(negedge lrck);
    endtask

    task automatic do_reset();
        @(negedge lrck);
        rst_n = 1'b0;
        bus.pluck = 1'b0;
        bus.fb_in = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        do_reset();
        chk_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %0b want 1", bus.busy);
        else pass_cnt++;
        chk_cnt++;
        if (bus.tap_out !== 24'sd0) $display("FAIL reset_tap: got %0h want 0", bus.tap_out);
        else pass_cnt++;
        n = 0;
        bad = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            tick();
            n++;
            if (bus.tap_out !== 24'sd0) bad++;
        end
        chk_cnt++;
        if (n != 1024) $display("FAIL clear_len: got %0d want 1024", n);
        else pass_cnt++;
        chk_cnt++;
        if (bad != 0) $display("FAIL clear_tap_zero: got %0d nonzero want 0", bad);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.tap_out !== 24'sd0 || bus.busy !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL run_idle: got %0d bad samples want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_pluck();
        int r;
        int n;
        bus.period = 10'd5;
        bus.amplitude = 23'h100000;
        bus.pluck = 1'b1;
        r = cyc;
        tick();
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        bus.pluck = 1'b0;
        chk_cnt++;
        if (n != 5) $display("FAIL pluck_busy_len: got %0d want 5", n);
        else pass_cnt++;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_cnt++;
            if (bus.tap_out !== noise_hist[r + k])
                $display("FAIL pluck_noise[%0d]: got %0h want %0h", k, bus.tap_out, noise_hist[r + k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_delay();
        logic signed [23:0] exp_v;
        bus.period = 10'd8;
        for (int i = 0; i < 24; i++) begin
            bus.fb_in = 24'(i + 1);
            tick();
            if (i >= 8) begin
                exp_v = 24'(i - 7);
                chk_cnt++;
                if (bus.tap_out !== exp_v)
                    $display("FAIL delay8[%0d]: got %0h want %0h", i, bus.tap_out, exp_v);
                else pass_cnt++;
            end
        end
        bus.fb_in = '0;
    endtask

    task automatic test_short_period();
        logic signed [23:0] exp_v;
        int r;
        int n;
        bus.period = 10'd0;
        for (int i = 0; i < 12; i++) begin
            bus.fb_in = 24'(100 + i);
            tick();
            if (i >= 4) begin
                exp_v = 24'(98 + i);
                chk_cnt++;
                if (bus.tap_out !== exp_v)
                    $display("FAIL delay_p0[%0d]: got %0h want %0h", i, bus.tap_out, exp_v);
                else pass_cnt++;
            end
        end
        bus.fb_in = '0;
        bus.amplitude = 23'h012345;
        for (int pv = 1; pv >= 0; pv--) begin
            bus.period = 10'(pv);
            tick();
            bus.pluck = 1'b1;
            r = cyc;
            tick();
            n = 0;
            while (bus.busy === 1'b1 && n < 50) begin
                n++;
                tick();
            end
            bus.pluck = 1'b0;
            chk_cnt++;
            if (n != 2) $display("FAIL short_busy_p%0d: got %0d want 2", pv, n);
            else pass_cnt++;
            for (int k = 1; k <= 2; k++) begin
                tick();
                chk_cnt++;
                if (bus.tap_out !== noise_hist[r + k])
                    $display("FAIL short_noise_p%0d[%0d]: got %0h want %0h", pv, k, bus.tap_out, noise_hist[r + k]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_rerise();
        int r;
        int n;
        bus.period = 10'd10;
        bus.amplitude = 23'h0ABCDE;
        tick();
        bus.pluck = 1'b1;
        r = cyc;
        tick();
        bus.pluck = 1'b0;
        tick();
        tick();
        bus.pluck = 1'b1;
        n = 3;
        for (int g = 0; g < 50; g++) begin
            tick();
            if (bus.busy !== 1'b1) break;
            n++;
        end
        bus.pluck = 1'b0;
        chk_cnt++;
        if (n != 13) $display("FAIL rerise_busy_len: got %0d want 13", n);
        else pass_cnt++;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_cnt++;
            if (bus.tap_out !== noise_hist[r + 3 + k])
                $display("FAIL rerise_noise[%0d]: got %0h want %0h", k, bus.tap_out, noise_hist[r + 3 + k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_clear_pluck();
        int c0;
        int n;
        bus.period = 10'd10;
        bus.amplitude = 23'h7FFFFF;
        do_reset();
        c0 = cyc;
        n = 0;
        while (bus.busy === 1'b1 && n < 3000) begin
            if (n == 100) bus.pluck = 1'b1;
            tick();
            n++;
        end
        bus.pluck = 1'b0;
        chk_cnt++;
        if (n != 1034) $display("FAIL clear_pluck_len: got %0d want 1034", n);
        else pass_cnt++;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_cnt++;
            if (bus.tap_out !== noise_hist[c0 + 1023 + k])
                $display("FAIL clear_pluck_noise[%0d]: got %0h want %0h", k, bus.tap_out, noise_hist[c0 + 1023 + k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_period_shrink();
        logic signed [23:0] exp_v;
        bus.period = 10'd100;
        do_reset();
        for (int i = 0; i < 1024; i++) tick();
        for (int k = 0; k <= 70; k++) begin
            bus.fb_in = 24'(1000 + k);
            if (k == 50) bus.period = 10'd10;
            tick();
            if (k >= 50) begin
                if (k == 50) exp_v = 24'sd0;
                else if (k <= 60) exp_v = 24'(949 + k);
                else exp_v = 24'(990 + k);
                chk_cnt++;
                if (bus.tap_out !== exp_v)
                    $display("FAIL shrink[%0d]: got %0h want %0h", k, bus.tap_out, exp_v);
                else pass_cnt++;
            end
        end
        bus.fb_in = '0;
    endtask

    task automatic test_reset_mid_excite();
        int n;
        bus.pluck = 1'b1;
        tick();
        tick();
        tick();
        chk_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL excite_busy: got %0b want 1", bus.busy);
        else pass_cnt++;
        rst_n = 1'b0;
        bus.pluck = 1'b0;
        tick();
        chk_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL abort_busy: got %0b want 1", bus.busy);
        else pass_cnt++;
        chk_cnt++;
        if (bus.tap_out !== 24'sd0) $display("FAIL abort_tap: got %0h want 0", bus.tap_out);
        else pass_cnt++;
        rst_n = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (n != 1024) $display("FAIL abort_clear_len: got %0d want 1024", n);
        else pass_cnt++;
    endtask

    initial begin
        bus.period = 10'd8;
        bus.pluck = 1'b0;
        bus.amplitude = '0;
        bus.fb_in = '0;
        test_reset();
        test_pluck();
        test_delay();
        test_short_period();
        test_rerise();
        test_clear_pluck();
        test_period_shrink();
        test_reset_mid_excite();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
